hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-003 SHALL have ports id_rs1_addr, id_rs2_addr  input  5  source register addresses of the instruction in ID.
REQ-004 SHALL have ports id_rs1_used, id_rs2_used  input  1  the ID instruction actually reads rs1 / rs2.
REQ-005 SHALL have ports exe_write_addr_o  input  5, exe_reg_write  input  1, and exe_DM_read  input  1, carrying the destination, write enable and load flag of the instruction in EXE.
REQ-006 SHALL have ports mem_write_addr  input  5 and mem_reg_write  input  1, carrying the destination and write enable of the instruction in MEM.
REQ-007 SHALL have port exe_branch_taken  input  1  the branch in EXE resolved as taken.
REQ-008 SHALL have ports mem_DM_req  input  1 (MEM stage is accessing data memory) and dm_ready  input  1 (data memory completes the access this cycle).
REQ-009 SHALL have outputs pc_stall, ifid_stall, ifid_flush, idexe_flush, exe_stall  output  1 each; idexe_flush = insert bubble (WriteDisable/ReadDisable/AluCtrlNop) into the ID/EXE register.
REQ-010 SHALL have ports fwd_a_sel, fwd_b_sel  output  2  operand forward select, present only with FORWARD_EN (REQ-024).
REQ-011 SHALL have port stall_cnt  output  16  count of cycles with pc_stall=1.

Function
REQ-012 SHALL use FSM states RUN, LDSTALL, FLUSH, MEMWAIT held in a state register; control outputs are combinational from state and inputs.
REQ-013 SHALL detect a RAW match when (id_rsN_used && id_rsN_addr==dest && dest!=0 && dest_write_enable) for N=1,2; register 0 never matches.
REQ-014 SHALL evaluate events in priority order: memory wait > branch taken > load-use > RAW stall (non-forward build only).
REQ-015 SHALL, on mem_DM_req=1 && dm_ready=0 in any state: assert pc_stall, ifid_stall and exe_stall; hold idexe_flush=0 and ifid_flush=0; next state MEMWAIT; remain in MEMWAIT until dm_ready=1.
REQ-016 SHALL, in the dm_ready=1 cycle, deassert all stalls and return to RUN; a branch or hazard present in that cycle is evaluated as in RUN.
REQ-017 SHALL, on exe_branch_taken=1 (no memory wait): assert ifid_flush and idexe_flush for that single cycle, with no stalls; next state FLUSH.
REQ-018 SHALL, in FLUSH: suppress load-use and RAW detection for one cycle (the ID stage holds a bubble), then return to RUN.
REQ-019 SHALL, on load-use (exe_DM_read=1 and a RAW match against the EXE destination): assert pc_stall, ifid_stall and idexe_flush for exactly one cycle; next state LDSTALL.
REQ-020 SHALL, in LDSTALL: suppress load-use detection for one cycle, then return to RUN.
REQ-021 SHALL increment stall_cnt by 1 on every clock edge at which pc_stall=1, saturating at 16'hFFFF with no wrap.

Reset
REQ-022 SHALL, while rst=0, hold state=RUN and stall_cnt=0 and force all control outputs to 0 (fwd selects 2'b00), independent of clk.
REQ-023 SHALL, when rst asserts mid-MEMWAIT or mid-LDSTALL, abandon that state immediately and resume in RUN on the first edge after rst=1.

Configuration
REQ-024 SHALL, with macro HAZARD_FORWARD_EN defined, drive fwd_x_sel = 2'b01 on a RAW match against EXE (non-load), else 2'b10 on a match against MEM, else 2'b00; EXE has priority over MEM; a non-load RAW causes no stall.
REQ-025 SHALL, without HAZARD_FORWARD_EN, omit fwd_a_sel and fwd_b_sel; any RAW match against EXE or MEM asserts pc_stall, ifid_stall and idexe_flush, repeating each cycle until no match remains.

Verification
REQ-026 SHALL cover load-use: exe_DM_read=1, exe_reg_write=1, exe_write_addr_o=5, id_rs1_addr=5, id_rs1_used=1 -> exactly one cycle of pc_stall/ifid_stall/idexe_flush, and stall_cnt 0->1.
REQ-027 SHALL cover branch: exe_branch_taken=1 for one cycle -> ifid_flush=idexe_flush=1 in that cycle only; a load-use match on the next cycle is ignored.
REQ-028 SHALL cover memory wait: mem_DM_req=1, dm_ready=0 for 3 cycles, then 1 -> pc_stall/ifid_stall/exe_stall high for 3 cycles, stall_cnt +3; a coincident branch is deferred to the ready cycle.
REQ-029 SHALL cover forwarding (HAZARD_FORWARD_EN): EXE and MEM both write r7, id_rs2_addr=7 -> fwd_b_sel=2'b01; with EXE not writing -> 2'b10; with id_rs2_addr=0 -> 2'b00.
REQ-030 SHALL cover reset and saturation: preload stall_cnt to 16'hFFFE and stall 3 cycles -> stall_cnt=16'hFFFF; rst=0 mid-MEMWAIT -> outputs 0 asynchronously and stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-stage status in, hazard control out.
// The fwd_a_sel/fwd_b_sel members exist only when HAZARD_FORWARD_EN is defined.
interface hazard_ctrl_if;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  exe_write_addr_o;
  logic        exe_reg_write;
  logic        exe_DM_read;
  logic [4:0]  mem_write_addr;
  logic        mem_reg_write;
  logic        exe_branch_taken;
  logic        mem_DM_req;
  logic        dm_ready;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idexe_flush;
  logic        exe_stall;
  logic [15:0] stall_cnt;
`ifdef HAZARD_FORWARD_EN
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           exe_write_addr_o, exe_reg_write, exe_DM_read,
           mem_write_addr, mem_reg_write, exe_branch_taken, mem_DM_req, dm_ready,
    input  pc_stall, ifid_stall, ifid_flush, idexe_flush, exe_stall, stall_cnt,
           fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           exe_write_addr_o, exe_reg_write, exe_DM_read,
           mem_write_addr, mem_reg_write, exe_branch_taken, mem_DM_req, dm_ready,
    output pc_stall, ifid_stall, ifid_flush, idexe_flush, exe_stall, stall_cnt,
           fwd_a_sel, fwd_b_sel
  );
`else
  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           exe_write_addr_o, exe_reg_write, exe_DM_read,
           mem_write_addr, mem_reg_write, exe_branch_taken, mem_DM_req, dm_ready,
    input  pc_stall, ifid_stall, ifid_flush, idexe_flush, exe_stall, stall_cnt
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           exe_write_addr_o, exe_reg_write, exe_DM_read,
           mem_write_addr, mem_reg_write, exe_branch_taken, mem_DM_req, dm_ready,
    output pc_stall, ifid_stall, ifid_flush, idexe_flush, exe_stall, stall_cnt
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for a 5-stage pipeline.
// Define HAZARD_FORWARD_EN to forward non-load RAW operands instead of stalling.
module hazard_ctrl (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, MEMWAIT} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_stall_cnt;
  logic          w_rs1_exe, w_rs2_exe, w_rs1_mem, w_rs2_mem;
  logic          w_lu_ok, w_raw_ok;
  logic          w_pc_stall, w_ifid_stall, w_ifid_flush, w_idexe_flush, w_exe_stall;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic raw_hit(input logic used, input logic [AW-1:0] src,
                                   input logic [AW-1:0] dest, input logic we);
    return used && (src == dest) && (dest != '0) && we;
  endfunction

  assign w_rs1_exe = raw_hit(bus.id_rs1_used, bus.id_rs1_addr, bus.exe_write_addr_o, bus.exe_reg_write);
  assign w_rs2_exe = raw_hit(bus.id_rs2_used, bus.id_rs2_addr, bus.exe_write_addr_o, bus.exe_reg_write);
  assign w_rs1_mem = raw_hit(bus.id_rs1_used, bus.id_rs1_addr, bus.mem_write_addr, bus.mem_reg_write);
  assign w_rs2_mem = raw_hit(bus.id_rs2_used, bus.id_rs2_addr, bus.mem_write_addr, bus.mem_reg_write);

  // After a flush ID holds a bubble; after a load-use stall the load has left EXE.
  assign w_lu_ok  = (r_state != FLUSH) && (r_state != LDSTALL);
  assign w_raw_ok = (r_state != FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_next;
  end

  // Priority: memory wait > taken branch > load-use > RAW stall.
  always_comb begin
    w_next        = RUN;
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idexe_flush = 1'b0;
    w_exe_stall   = 1'b0;
    if (bus.mem_DM_req && !bus.dm_ready) begin
      w_pc_stall   = 1'b1;
      w_ifid_stall = 1'b1;
      w_exe_stall  = 1'b1;
      w_next       = MEMWAIT;
    end else if (bus.exe_branch_taken) begin
      w_ifid_flush  = 1'b1;
      w_idexe_flush = 1'b1;
      w_next        = FLUSH;
    end else if (w_lu_ok && bus.exe_DM_read && (w_rs1_exe || w_rs2_exe)) begin
      w_pc_stall    = 1'b1;
      w_ifid_stall  = 1'b1;
      w_idexe_flush = 1'b1;
      w_next        = LDSTALL;
    end
`ifndef HAZARD_FORWARD_EN
    else if (w_raw_ok && (w_rs1_exe || w_rs2_exe || w_rs1_mem || w_rs2_mem)) begin
      w_pc_stall    = 1'b1;
      w_ifid_stall  = 1'b1;
      w_idexe_flush = 1'b1;
    end
`endif
  end

`ifdef HAZARD_FORWARD_EN
  logic [1:0] w_fwd_a, w_fwd_b;

  // A load in EXE cannot forward; its data comes from MEM after the load-use stall.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (w_raw_ok) begin
      if (w_rs1_exe && !bus.exe_DM_read) w_fwd_a = 2'b01;
      else if (w_rs1_mem)                w_fwd_a = 2'b10;
      if (w_rs2_exe && !bus.exe_DM_read) w_fwd_b = 2'b01;
      else if (w_rs2_mem)                w_fwd_b = 2'b10;
    end
  end

  assign bus.fwd_a_sel = rst ? w_fwd_a : 2'b00;
  assign bus.fwd_b_sel = rst ? w_fwd_b : 2'b00;
`endif

  // Reset masks the combinational outputs without waiting for a clock.
  assign bus.pc_stall    = rst & w_pc_stall;
  assign bus.ifid_stall  = rst & w_ifid_stall;
  assign bus.ifid_flush  = rst & w_ifid_flush;
  assign bus.idexe_flush = rst & w_idexe_flush;
  assign bus.exe_stall   = rst & w_exe_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      r_stall_cnt <= '0;
    else if (w_pc_stall && r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CW'(1);
  end

  assign bus.stall_cnt = r_stall_cnt;
endmodule
